// File: rtl/sync_delay_pkg.sv
// Shared types and helpers for the sync/blank delay controller.
// The state enum, the default idle level of the sync bundle and the
// delay clamp are used by both the controller and the bench.
package sync_delay_pkg;

    // Controller phases:
    // FLUSH   - output parked at the idle level while the tap line refills.
    // RUN     - delayed sync bundle is passed through.
    // PENDING - new delay waits for the next frame boundary.
    typedef enum logic [1:0] {
        FLUSH   = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_e;

    // Idle level of {blank, vsync, hsync}: syncs inactive-high, blank low.
    localparam logic [2:0] IDLE_LEVEL_DEFAULT = 3'b011;

    // Map any requested delay into the supported range 1..max_d.
    function automatic int clamp_delay(input int req, input int max_d);
        if (req < 1) begin
            return 1;
        end
        if (req > max_d) begin
            return max_d;
        end
        return req;
    endfunction

endpackage : sync_delay_pkg

// File: rtl/sync_delay_tap_line.sv
// Variable-tap shift line for the sync/blank bundle.
// The line shifts unconditionally every cycle; only the tap select moves.
// Total latency from din to tap_out is exactly tap_sel register stages:
// tap_sel=1 is a single register, tap_sel=k uses k-1 line stages plus
// the registered tap. The deepest tap therefore needs DEPTH-1 line stages.
module delay_tap_line #(
    parameter int                N_SIG      = 3,
    parameter int                DEPTH      = 16,
    parameter int                DW         = 5,
    parameter logic [N_SIG-1:0]  IDLE_LEVEL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SIG-1:0] din,
    input  logic [DW-1:0]    tap_sel,
    output logic [N_SIG-1:0] tap_out
);

    localparam int STAGES = DEPTH - 1;

    logic [N_SIG-1:0] line_q [STAGES];
    logic [N_SIG-1:0] tap_d;
    logic [N_SIG-1:0] tap_q;

    // Free-running shift line, cleared to the idle level on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                line_q[i] <= IDLE_LEVEL;
            end
        end else begin
            line_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    // Tap select: delay 1 takes din directly, delay k takes stage k-2.
    always_comb begin
        tap_d = din;
        for (int i = 0; i < STAGES; i++) begin
            if (int'(tap_sel) == i + 2) begin
                tap_d = line_q[i];
            end
        end
    end

    // Registered tap output so the selected delay is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= IDLE_LEVEL;
        end else begin
            tap_q <= tap_d;
        end
    end

    assign tap_out = tap_q;

endmodule : delay_tap_line

// File: rtl/sync_delay_ctrl.sv
// Runtime-programmable delay controller for the VGA sync/blank bundle.
// A new delay is accepted through a valid/ready handshake, held until the
// next frame boundary (vsync 0->1), then applied behind a flush window in
// which sig_out is parked at IDLE_LEVEL for exactly the new delay, so the
// monitor never sees a torn sync edge in mid-frame.
// Optional build macro: SYNC_DELAY_HALF_CYCLE_EN adds a falling-edge
// retiming register on sig_out (latency D + 0.5 cycles).
module sync_delay_ctrl
    import sync_delay_pkg::*;
#(
    parameter int               N_SIG         = 3,
    parameter int               MAX_DELAY     = 16,
    parameter int               DEFAULT_DELAY = 4,
    parameter int               FRAME_BIT     = 1,
    parameter logic [N_SIG-1:0] IDLE_LEVEL    = N_SIG'(IDLE_LEVEL_DEFAULT),
    localparam int              DW            = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SIG-1:0] sig_in,
    output logic [N_SIG-1:0] sig_out,
    input  logic [DW-1:0]    cfg_delay,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic [DW-1:0]    active_delay,
    output logic             busy,
    output state_e           dbg_state
);

    localparam logic [DW-1:0] RST_DELAY = DW'(clamp_delay(DEFAULT_DELAY, MAX_DELAY));
    localparam logic          IDLE_FB   = IDLE_LEVEL[FRAME_BIT];

    // Handshake: a request transfers on a rising edge where cfg_valid and
    // cfg_ready are both high. cfg_ready is a register; it is low in FLUSH
    // and also low in the PENDING cycle in which the frame edge is acted on,
    // so a request offered in that cycle is simply not taken and must be
    // re-offered. cfg_delay is only looked at when a transfer happens.

    state_e          state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   pend_q, pend_d;
    logic [DW-1:0]   act_q, act_d;
    logic            ready_q, ready_d;
    logic            busy_q;
    logic            out_idle_q;
    logic            fb_q, fb_prev_q;

    logic            frame_edge;
    logic            edge_next;
    logic            handshake;
    logic [DW-1:0]   req_clamped;
    logic [N_SIG-1:0] tap_w;
    logic [N_SIG-1:0] out_mux;

    // The frame bit is sampled into fb_q; the edge is formed from that
    // sample and the one before, so it is known one cycle ahead and the
    // registered cfg_ready can already be low in the cycle it is used.
    assign frame_edge  = fb_q & ~fb_prev_q;
    assign edge_next   = sig_in[FRAME_BIT] & ~fb_q;
    assign handshake   = cfg_valid & ready_q;
    assign req_clamped = DW'(clamp_delay(int'(cfg_delay), MAX_DELAY));

    // Next-state logic for the FLUSH / RUN / PENDING sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        act_d   = act_q;
        unique case (state_q)
            FLUSH: begin
                if (cnt_q <= DW'(1)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
            RUN: begin
                if (handshake) begin
                    pend_d  = req_clamped;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (frame_edge) begin
                    act_d   = pend_q;
                    cnt_d   = pend_q;
                    state_d = FLUSH;
                end else if (handshake) begin
                    pend_d = req_clamped;
                end
            end
            default: begin
                state_d = FLUSH;
                cnt_d   = act_q;
            end
        endcase
    end

    // Ready for the coming cycle: never in FLUSH, and not in the PENDING
    // cycle where the frame edge will switch to the pending delay.
    assign ready_d = (state_d != FLUSH) && !((state_d == PENDING) && edge_next);

    // Sequencer state plus its registered outputs and the edge samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FLUSH;
            cnt_q      <= RST_DELAY;
            pend_q     <= RST_DELAY;
            act_q      <= RST_DELAY;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            out_idle_q <= 1'b1;
            fb_q       <= IDLE_FB;
            fb_prev_q  <= IDLE_FB;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            act_q      <= act_d;
            ready_q    <= ready_d;
            busy_q     <= (state_d != RUN);
            out_idle_q <= (state_q == FLUSH);
            fb_q       <= sig_in[FRAME_BIT];
            fb_prev_q  <= fb_q;
        end
    end

    delay_tap_line #(
        .N_SIG      (N_SIG),
        .DEPTH      (MAX_DELAY),
        .DW         (DW),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_tap_line (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (sig_in),
        .tap_sel (act_q),
        .tap_out (tap_w)
    );

    // Both mux inputs are registers updated on the same edge, so the
    // switch into and out of the idle level lines up with a clock edge.
    assign out_mux = out_idle_q ? IDLE_LEVEL : tap_w;

`ifdef SYNC_DELAY_HALF_CYCLE_EN
    logic [N_SIG-1:0] out_neg_q;

    // Falling-edge retiming stage in front of the pads.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_neg_q <= IDLE_LEVEL;
        end else begin
            out_neg_q <= out_mux;
        end
    end

    assign sig_out = out_neg_q;
`else
    assign sig_out = out_mux;
`endif

    assign cfg_ready    = ready_q;
    assign busy         = busy_q;
    assign active_delay = act_q;
    assign dbg_state    = state_q;

endmodule : sync_delay_ctrl

// File: tb/tb_sync_delay_ctrl.sv
// Bench for sync_delay_ctrl: directed steps from the test plan mixed with
// randomized sync traffic and requests, checked every cycle against a
// cycle-level reference model of the delay/flush/pending rules.
module tb_sync_delay_ctrl;
    import sync_delay_pkg::*;

    localparam int         N_SIG     = 3;
    localparam int         MAX_DELAY = 16;
    localparam int         DW        = $clog2(MAX_DELAY + 1);
    localparam logic [2:0] IDLE      = 3'b011;
    localparam int         DEF_D     = 4;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_SIG-1:0] sig_in = IDLE;
    logic [N_SIG-1:0] sig_out;
    logic [DW-1:0]    cfg_delay = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [DW-1:0]    active_delay;
    logic             busy;
    state_e           dbg_state;

    always #5 clk = ~clk;

    sync_delay_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .sig_out      (sig_out),
        .cfg_delay    (cfg_delay),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .active_delay (active_delay),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- reference model ----------------
    int         checks = 0;
    int         errors = 0;
    int         k = 0;              // rising edges since reset release
    logic [2:0] in_hist[$];         // sig_in driven in cycle i (before edge i+1)
    bit         drv_valid;
    int         drv_delay;
    bit         vs_lvl;

    int         m_act;              // delay in force
    int         m_flush_left;       // remaining idle cycles, >0 means flushing
    bit         m_has_pend;
    int         m_pend;
    logic [2:0] m_out;
    bit         m_ready;

    function automatic int clamp_ref(input int v);
        if (v == 0) return 1;
        if (v > MAX_DELAY) return MAX_DELAY;
        return v;
    endfunction

    function automatic logic [2:0] hist(input int idx);
        if (idx < 0) return IDLE;
        return in_hist[idx];
    endfunction

    // vsync driven in cycle idx is 1 and was 0 in cycle idx-1
    function automatic bit vs_rise(input int idx);
        logic [2:0] a;
        logic [2:0] b;
        a = hist(idx);
        b = hist(idx - 1);
        return a[1] && !b[1];
    endfunction

    task automatic model_reset();
        in_hist.delete();
        k            = 0;
        m_act        = DEF_D;
        m_flush_left = DEF_D;
        m_has_pend   = 0;
        m_pend       = 0;
        m_out        = IDLE;
        m_ready      = 0;
    endtask

    // Advance the model across rising edge k.
    task automatic model_edge();
        bit fe;
        bit hs;
        fe = vs_rise(k - 2);
        hs = drv_valid && m_ready;
        if (m_flush_left > 0) begin
            m_out = IDLE;
            m_flush_left--;
        end else begin
            m_out = hist(k - m_act);
            if (m_has_pend) begin
                if (fe) begin
                    m_act        = m_pend;
                    m_flush_left = m_pend;
                    m_has_pend   = 0;
                end else if (hs) begin
                    m_pend = clamp_ref(drv_delay);
                end
            end else if (hs) begin
                m_has_pend = 1;
                m_pend     = clamp_ref(drv_delay);
            end
        end
        m_ready = (m_flush_left == 0) && !(m_has_pend && vs_rise(k - 1));
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic check_all();
        state_e exp_st;
        exp_st = (m_flush_left > 0) ? FLUSH : (m_has_pend ? PENDING : RUN);
        chk("sig_out", 32'(sig_out), 32'(m_out));
        chk("busy", 32'(busy), 32'(m_flush_left > 0 || m_has_pend));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        chk("active_delay", 32'(active_delay), 32'(m_act));
        chk("state", 32'(dbg_state), 32'(exp_st));
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        model_edge();
        check_all();
    endtask

    task automatic cycle(input bit v, input int d);
        logic [2:0] s;
        s[0] = 1'($urandom_range(0, 1));
        s[1] = vs_lvl;
        s[2] = 1'($urandom_range(0, 1));
        sig_in    = s;
        cfg_valid = v;
        cfg_delay = DW'(d);
        in_hist.push_back(s);
        drv_valid = v;
        drv_delay = d;
        tick();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_all();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int cnt7;
        vs_lvl    = 0;
        drv_valid = 0;
        drv_delay = 0;
        model_reset();

        // Reset values while held in reset
        repeat (3) @(posedge clk);
        #1;
        check_all();
        release_reset();

        // Flush of DEFAULT_DELAY then pass-through with 4-cycle latency
        idle_cycles(24);
        chk("run_after_reset", 32'(busy), 32'(0));

        // Request 7: held until the vsync rise, then exactly 7 busy cycles
        cycle(1, 7);
        idle_cycles(10);
        chk("held_until_edge", 32'(active_delay), 32'(4));
        vs_lvl = 1;
        cnt7 = 0;
        for (int i = 0; i < 24; i++) begin
            cycle(0, 0);
            if (busy && active_delay == DW'(7)) cnt7++;
        end
        chk("flush_len7", 32'(cnt7), 32'(7));
        vs_lvl = 0;
        idle_cycles(10);

        // Two requests in one frame: last wins
        cycle(1, 9);
        idle_cycles(5);
        cycle(1, 2);
        idle_cycles(5);
        vs_lvl = 1;
        idle_cycles(25);
        chk("last_wins", 32'(active_delay), 32'(2));
        vs_lvl = 0;
        idle_cycles(5);

        // Clamping of 0 and out-of-range requests
        cycle(1, 0);
        idle_cycles(3);
        vs_lvl = 1;
        idle_cycles(10);
        chk("clamp_low", 32'(active_delay), 32'(1));
        vs_lvl = 0;
        idle_cycles(3);
        cycle(1, 31);
        idle_cycles(3);
        vs_lvl = 1;
        idle_cycles(25);
        chk("clamp_high", 32'(active_delay), 32'(16));
        vs_lvl = 0;
        idle_cycles(5);

        // Request offered in the cycle the frame edge is acted on
        cycle(1, 5);
        idle_cycles(4);
        vs_lvl = 1;
        cycle(0, 0);
        chk("ready_low_at_edge", 32'(cfg_ready), 32'(0));
        cycle(1, 9);
        chk("edge_wins", 32'(active_delay), 32'(5));
        idle_cycles(12);
        chk("dropped_req", 32'(busy), 32'(0));
        vs_lvl = 0;
        idle_cycles(3);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 24) == 0) vs_lvl = ~vs_lvl;
            if ($urandom_range(0, 7) == 0) cycle(1, int'($urandom_range(0, 31)));
            else cycle(0, 0);
        end

        // Settle into RUN, then reset while a request is pending
        vs_lvl = 0;
        idle_cycles(3);
        vs_lvl = 1;
        idle_cycles(3);
        vs_lvl = 0;
        idle_cycles(25);
        cycle(1, 10);
        idle_cycles(3);
        chk("pending_before_reset", 32'(busy), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        release_reset();
        idle_cycles(20);
        vs_lvl = 1;
        idle_cycles(20);
        chk("pending_lost", 32'(active_delay), 32'(DEF_D));
        vs_lvl = 0;
        idle_cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sync_delay_ctrl
